modn_down_timer: RTL and testbench
==================================

MODN_DOWN_TIMER -- requirements
Module: modn_down_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter bit-width.
REQ-002 The block SHALL have parameter WRAP_W, default 8, giving the wrap-counter bit-width.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port en  input  1  count enable; decrement permitted only when high.
REQ-006 Port load  input  1  synchronous load/start strobe.
REQ-007 Port load_val  input  WIDTH  start value captured on load.
REQ-008 Port mod_n  input  WIDTH  runtime modulus; reload value is mod_n-1.
REQ-009 Port one_shot  input  1  sampled on load: 1 = stop at zero, 0 = auto-reload.
REQ-010 Port count  output  WIDTH  current count value (registered).
REQ-011 Port tc  output  1  terminal-count pulse (registered).
REQ-012 Port busy  output  1  high while in RUN.
REQ-013 Port done  output  1  high while in DONE (one-shot expired).
REQ-014 Port wraps  output  WRAP_W  number of auto-reloads, modulo 2^WRAP_W.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE), both registered-state decodes.
REQ-016 Effective modulus M SHALL be mod_n, except mod_n==0 is treated as M=1.
REQ-017 load SHALL have priority over every other event in every state: count <= min(load_val, M-1), the mode register <= one_shot, tc <= 0, state <= RUN on the same edge.
REQ-018 In RUN with en=1 and count!=0, count SHALL decrement by exactly 1 per edge; en=0 holds count, state, tc=0.
REQ-019 In RUN with en=1 and count==0, tc SHALL be 1 for exactly the following cycle (one-cycle latency from the zero-count edge).
REQ-020 On that edge in auto-reload mode: count <= M-1, wraps increments by 1 (wrapping at 2^WRAP_W), state stays RUN.
REQ-021 On that edge in one-shot mode: count stays 0, state <= DONE, wraps unchanged.
REQ-022 With M=1, auto-reload SHALL produce tc on every enabled cycle with count fixed at 0.
REQ-023 A mod_n change during RUN SHALL take effect only at the next reload or load; count is never re-clipped mid-run.
REQ-024 In IDLE and DONE, en SHALL be ignored, count held, tc=0.
REQ-025 Simultaneous load and terminal-count edge: load wins, no tc pulse, no wraps increment.
REQ-026 tc SHALL never be high in two consecutive cycles unless M=1 in auto-reload with en held high.

Reset
REQ-027 On rst_n low, asynchronously: state=IDLE, count=0, tc=0, busy=0, done=0, wraps=0, mode register=0.
REQ-028 Reset mid-RUN SHALL abandon the run with no tc pulse; after release, the block stays in IDLE until load.
REQ-029 Reset release SHALL not itself cause a decrement; first state change requires load.

Structure
REQ-030 A shared package modn_down_pkg SHALL hold the FSM state type (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH/WRAP_W constants.
REQ-031 One sub-module, wrap_counter (WRAP_W-bit up counter with increment enable, async active-low reset, clk/rst_n), SHALL implement wraps; all else stays in modn_down_timer.

Verification
REQ-032 mod_n=5, load_val=4, one_shot=0, en=1: count 4,3,2,1,0,4,3...; tc high the cycle count shows 4 after 0; wraps=1 after first reload.
REQ-033 mod_n=5, load_val=9, one_shot=1: count clipped to 4, reaches 0, tc one cycle, then done=1, busy=0, count=0 held with en=1.
REQ-034 mod_n=0, one_shot=0, en=1 for 4 cycles after load: count=0 throughout, tc high 4 consecutive cycles, wraps=4.
REQ-035 RUN at count=2, en toggled 1,0,0,1: count 2,1,1,1,0; no tc during en=0.
REQ-036 load asserted on the edge where count==0, en=1, load_val=3: count=3, tc=0, wraps unchanged.
REQ-037 rst_n pulsed low at count=2 in RUN: immediately count=0, busy=0, wraps=0; en=1 afterwards leaves IDLE unchanged until load.

Source files
------------

// File: rtl/modn_down_pkg.sv
// Shared types and defaults for the modulo-N down timer.
package modn_down_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_WRAP_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/wrap_counter.sv
// Free-running up counter of auto-reload events, wrapping at 2^WRAP_W.
module wrap_counter
  import modn_down_pkg::*;
#(
  parameter int unsigned WRAP_W = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_i,
  output logic [WRAP_W-1:0] count_o
);

  logic [WRAP_W-1:0] count_q;
  logic [WRAP_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = count_q + WRAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/modn_down_timer.sv
// Modulo-N down counter with one-shot / auto-reload modes and a registered
// terminal-count pulse; load always takes priority.
module modn_down_timer
  import modn_down_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned WRAP_W = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  mod_n,
  input  logic              one_shot,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              busy,
  output logic              done,
  output logic [WRAP_W-1:0] wraps
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;
  logic             wrap_inc;
  logic [WIDTH-1:0] reload_val;
  logic [WIDTH-1:0] load_clip;

  // mod_n == 0 behaves as a modulus of 1, so the reload value is 0.
  assign reload_val = (mod_n == '0) ? '0 : (mod_n - WIDTH'(1));
  assign load_clip  = (load_val > reload_val) ? reload_val : load_val;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;
    wrap_inc = 1'b0;
    if (load) begin
      state_d = RUN;
      count_d = load_clip;
      mode_d  = one_shot;
    end else begin
      case (state_q)
        RUN: begin
          if (en) begin
            if (count_q != '0) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              tc_d = 1'b1;
              if (mode_q) begin
                state_d = DONE;
              end else begin
                count_d  = reload_val;
                wrap_inc = 1'b1;
              end
            end
          end
        end
        IDLE, DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      mode_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      tc_q    <= tc_d;
    end
  end

  wrap_counter #(
    .WRAP_W (WRAP_W)
  ) u_wrap_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (wrap_inc),
    .count_o (wraps)
  );

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_modn_down_timer.sv
// Directed bench for modn_down_timer: one task per scenario, inline checks.
module tb_modn_down_timer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] mod_n;
  logic       one_shot;
  logic [7:0] count;
  logic       tc;
  logic       busy;
  logic       done;
  logic [7:0] wraps;

  int tests_run;
  int tests_failed;

  modn_down_timer #(
    .WIDTH  (8),
    .WRAP_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .mod_n    (mod_n),
    .one_shot (one_shot),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .done     (done),
    .wraps    (wraps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    load     = 1'b0;
    en       = 1'b0;
    load_val = '0;
    mod_n    = '0;
    one_shot = 1'b0;
    rst_n    = 1'b0;
    #2;
    rst_n    = 1'b1;
    step();
  endtask

  task automatic test_reset();
    load = 1'b1; load_val = 8'd3; mod_n = 8'd5; en = 1'b1;
    rst_n = 1'b0;
    step();
    tests_run++;
    if ({count, tc, busy, done, wraps} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got count=%0d tc=%0b busy=%0b done=%0b wraps=%0d, expected all 0",
               count, tc, busy, done, wraps);
    end
    load = 1'b0; en = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_autoreload();
    int exp_cnt[7]  = '{3, 2, 1, 0, 4, 3, 2};
    int exp_tc[7]   = '{0, 0, 0, 0, 1, 0, 0};
    int exp_wrap[7] = '{0, 0, 0, 0, 1, 1, 1};
    do_reset();
    mod_n = 8'd5; load_val = 8'd4; one_shot = 1'b0; en = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    tests_run++;
    if (count !== 8'd4 || busy !== 1'b1 || tc !== 1'b0) begin
      tests_failed++;
      $display("FAIL autoreload_load: got count=%0d busy=%0b tc=%0b, expected 4 1 0", count, busy, tc);
    end
    for (int i = 0; i < 7; i++) begin
      step();
      tests_run++;
      if (count !== 8'(exp_cnt[i]) || tc !== 1'(exp_tc[i]) || wraps !== 8'(exp_wrap[i]) || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL autoreload_cycle%0d: got count=%0d tc=%0b wraps=%0d busy=%0b, expected %0d %0d %0d 1",
                 i, count, tc, wraps, busy, exp_cnt[i], exp_tc[i], exp_wrap[i]);
      end
    end
  endtask

  task automatic test_oneshot();
    int exp_cnt[4] = '{3, 2, 1, 0};
    do_reset();
    mod_n = 8'd5; load_val = 8'd9; one_shot = 1'b1; en = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    tests_run++;
    if (count !== 8'd4) begin
      tests_failed++;
      $display("FAIL oneshot_clip: got count=%0d, expected 4", count);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (count !== 8'(exp_cnt[i]) || tc !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL oneshot_cycle%0d: got count=%0d tc=%0b busy=%0b done=%0b, expected %0d 0 1 0",
                 i, count, tc, busy, done, exp_cnt[i]);
      end
    end
    step();
    tests_run++;
    if (count !== 8'd0 || tc !== 1'b1 || busy !== 1'b0 || done !== 1'b1 || wraps !== 8'd0) begin
      tests_failed++;
      $display("FAIL oneshot_expire: got count=%0d tc=%0b busy=%0b done=%0b wraps=%0d, expected 0 1 0 1 0",
               count, tc, busy, done, wraps);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (count !== 8'd0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
        tests_failed++;
        $display("FAIL oneshot_hold%0d: got count=%0d tc=%0b busy=%0b done=%0b, expected 0 0 0 1",
                 i, count, tc, busy, done);
      end
    end
  endtask

  task automatic test_mod_zero();
    do_reset();
    mod_n = 8'd0; load_val = 8'd7; one_shot = 1'b0; en = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    tests_run++;
    if (count !== 8'd0 || tc !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL modzero_load: got count=%0d tc=%0b busy=%0b, expected 0 0 1", count, tc, busy);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      tests_run++;
      if (count !== 8'd0 || tc !== 1'b1 || wraps !== 8'(i)) begin
        tests_failed++;
        $display("FAIL modzero_cycle%0d: got count=%0d tc=%0b wraps=%0d, expected 0 1 %0d",
                 i, count, tc, wraps, i);
      end
    end
  endtask

  task automatic test_enable_gate();
    logic en_seq[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   exp_cnt[4] = '{1, 1, 1, 0};
    do_reset();
    mod_n = 8'd5; load_val = 8'd2; one_shot = 1'b0; en = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    tests_run++;
    if (count !== 8'd2) begin
      tests_failed++;
      $display("FAIL engate_load: got count=%0d, expected 2", count);
    end
    for (int i = 0; i < 4; i++) begin
      en = en_seq[i];
      step();
      tests_run++;
      if (count !== 8'(exp_cnt[i]) || tc !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL engate_cycle%0d: got count=%0d tc=%0b busy=%0b, expected %0d 0 1",
                 i, count, tc, busy, exp_cnt[i]);
      end
    end
  endtask

  task automatic test_load_vs_tc();
    do_reset();
    mod_n = 8'd5; load_val = 8'd1; one_shot = 1'b0; en = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    step();
    tests_run++;
    if (count !== 8'd0) begin
      tests_failed++;
      $display("FAIL loadtc_pre: got count=%0d, expected 0", count);
    end
    load = 1'b1; load_val = 8'd3;
    step();
    load = 1'b0;
    tests_run++;
    if (count !== 8'd3 || tc !== 1'b0 || wraps !== 8'd0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL loadtc_collide: got count=%0d tc=%0b wraps=%0d busy=%0b, expected 3 0 0 1",
               count, tc, wraps, busy);
    end
    step();
    tests_run++;
    if (count !== 8'd2 || tc !== 1'b0) begin
      tests_failed++;
      $display("FAIL loadtc_after: got count=%0d tc=%0b, expected 2 0", count, tc);
    end
  endtask

  task automatic test_modn_change();
    int exp_cnt[5] = '{3, 2, 1, 0, 2};
    do_reset();
    mod_n = 8'd5; load_val = 8'd4; one_shot = 1'b0; en = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    mod_n = 8'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (count !== 8'(exp_cnt[i]) || tc !== (i == 4)) begin
        tests_failed++;
        $display("FAIL modchange_cycle%0d: got count=%0d tc=%0b, expected %0d %0b",
                 i, count, tc, exp_cnt[i], (i == 4));
      end
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    mod_n = 8'd3; load_val = 8'd1; one_shot = 1'b0; en = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    tests_run++;
    if (count !== 8'd2 || wraps !== 8'd1 || tc !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrun_pre: got count=%0d wraps=%0d tc=%0b, expected 2 1 1", count, wraps, tc);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (count !== 8'd0 || busy !== 1'b0 || wraps !== 8'd0 || tc !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrun_async: got count=%0d busy=%0b wraps=%0d tc=%0b, expected 0 0 0 0",
               count, busy, wraps, tc);
    end
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin
        tests_failed++;
        $display("FAIL midrun_idle%0d: got count=%0d busy=%0b done=%0b tc=%0b, expected 0 0 0 0",
                 i, count, busy, done, tc);
      end
    end
    load = 1'b1; load_val = 8'd2;
    step();
    load = 1'b0;
    tests_run++;
    if (count !== 8'd2 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrun_reload: got count=%0d busy=%0b, expected 2 1", count, busy);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    load     = 1'b0;
    load_val = '0;
    mod_n    = '0;
    one_shot = 1'b0;
    test_reset();
    test_autoreload();
    test_oneshot();
    test_mod_zero();
    test_enable_gate();
    test_load_vs_tc();
    test_modn_change();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
